// File: rtl/i2s_cfg_ctrl.sv
// i2s_cfg_ctrl -- configuration/control unit for the I2S transceiver.
//
// The host writes shadow registers over a simple strobe bus. A commit
// command arms a transfer of the shadow set into the active configuration.
// The transfer happens at the next frame boundary or, with the link
// disabled, on the next clock edge. It only happens when the shadow set
// passes the legality check; an illegal set raises a sticky error instead.
//
// Ports:
//   clk, rst          system clock, asynchronous active-high reset
//   wr_en, rd_en      host write / read strobes
//   addr, wdata       host register address and write data
//   rdata, rd_valid   registered read data, valid one cycle after rd_en
//   frame_start       one-cycle frame boundary pulse from the WS generator
//   cfg_*             active configuration towards clock gen / serdes
//   cfg_update        one-cycle pulse when the active configuration changed
//
// Register map:
//   0 CTRL   (RW shadow) [1:0] mode, [3:2] standard, [5:4] word_size,
//                        [7:6] slot_size field, [9:8] sample_rate, [31] enable
//   1 CHEN   (RW shadow) [NUM_CH-1:0] slot enables
//   2 STATUS (RO)        [0] pending, [1] err, [2] active enable
//   3 CMD    (WO, reads 0) [0] commit, [1] clear err
//
// Host bus handshake: there is no back-pressure. A write is accepted on
// every edge where wr_en is high. A read is accepted on every edge where
// rd_en is high; rd_valid is high for exactly the following cycle with
// rdata holding the register value as it was before that edge. A write and
// a read on the same edge are both performed, and the read sees the old
// value.

module i2s_cfg_ctrl #(
  parameter int NUM_CH = 2,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              rd_valid,
  input  logic              frame_start,
  output logic              cfg_enable,
  output logic [1:0]        cfg_mode,
  output logic [1:0]        cfg_standard,
  output logic [1:0]        cfg_word_size,
  output logic              cfg_slot_size,
  output logic [1:0]        cfg_sample_rate,
  output logic [NUM_CH-1:0] cfg_ch_en,
  output logic              cfg_update
);

  // Enable sits at bit 31; on a narrower bus it moves to the top bit.
  localparam int EN_BIT = (DATA_W > 31) ? 31 : DATA_W - 1;

  localparam logic [ADDR_W-1:0] A_CTRL = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] A_CHEN = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] A_STAT = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] A_CMD  = ADDR_W'(3);

  // Slots 0 and 1 are the only ones a non-TDM standard may enable.
  localparam logic [NUM_CH-1:0] LO_SLOTS = NUM_CH'(3);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  // FSM and active configuration
  state_t            state_q;
  logic              err_q;
  logic              cfg_update_q;
  logic              act_en_q;
  logic [1:0]        act_mode_q;
  logic [1:0]        act_std_q;
  logic [1:0]        act_word_q;
  logic              act_slot_q;
  logic [1:0]        act_rate_q;
  logic [NUM_CH-1:0] act_chen_q;

  // Shadow registers
  logic              sh_en_q;
  logic [1:0]        sh_mode_q;
  logic [1:0]        sh_std_q;
  logic [1:0]        sh_word_q;
  logic [1:0]        sh_slot_q;
  logic [1:0]        sh_rate_q;
  logic [NUM_CH-1:0] sh_chen_q;

  // Read port
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] rdata_d;
  logic              rd_valid_q;

  // Decoded host strobes
  logic wr_ctrl;
  logic wr_chen;
  logic cmd_commit;
  logic cmd_clr_err;

  logic pending;
  logic apply_now;
  logic shadow_legal;
  logic chen_hi;

  // Only some wdata bits carry register fields; fold the rest here.
  logic unused_wdata;
  assign unused_wdata = ^wdata;

  assign wr_ctrl     = wr_en && (addr == A_CTRL);
  assign wr_chen     = wr_en && (addr == A_CHEN);
  assign cmd_commit  = wr_en && (addr == A_CMD) && wdata[0];
  assign cmd_clr_err = wr_en && (addr == A_CMD) && wdata[1];

  assign pending   = (state_q == ST_WAIT);
  // A disabled link has no frame timing to respect, so apply at once.
  assign apply_now = pending && (!act_en_q || frame_start);

  // Legality of the shadow set as it stands before the current edge.
  always_comb begin
    chen_hi      = |(sh_chen_q & ~LO_SLOTS);
    shadow_legal = 1'b1;
    if (sh_word_q == 2'b11) begin
      shadow_legal = 1'b0;
    end
    if (sh_slot_q[1]) begin
      shadow_legal = 1'b0;
    end
    if ((sh_word_q != 2'b00) && (sh_slot_q == 2'b00)) begin
      shadow_legal = 1'b0;
    end
    if ((sh_std_q == 2'b11) && (NUM_CH <= 2)) begin
      shadow_legal = 1'b0;
    end
    if ((sh_std_q != 2'b11) && chen_hi) begin
      shadow_legal = 1'b0;
    end
    if (sh_en_q && (sh_chen_q == '0)) begin
      shadow_legal = 1'b0;
    end
  end

  // Commit FSM plus active configuration. The apply decision is taken on
  // the edge that leaves WAIT; there is no separate apply state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      err_q        <= 1'b0;
      cfg_update_q <= 1'b0;
      act_en_q     <= 1'b0;
      act_mode_q   <= 2'b00;
      act_std_q    <= 2'b00;
      act_word_q   <= 2'b00;
      act_slot_q   <= 1'b0;
      act_rate_q   <= 2'b00;
      act_chen_q   <= '1;
    end else begin
      cfg_update_q <= 1'b0;
      if (cmd_clr_err) begin
        err_q <= 1'b0;
      end
      case (state_q)
        ST_IDLE: begin
          if (cmd_commit) begin
            state_q <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // A further commit while waiting is deliberately ignored.
          if (apply_now) begin
            state_q <= ST_IDLE;
            if (shadow_legal) begin
              act_en_q     <= sh_en_q;
              act_mode_q   <= sh_mode_q;
              act_std_q    <= sh_std_q;
              act_word_q   <= sh_word_q;
              act_slot_q   <= sh_slot_q[0];
              act_rate_q   <= sh_rate_q;
              act_chen_q   <= sh_chen_q;
              cfg_update_q <= 1'b1;
            end else begin
              // Placed after the clear above so a same-edge error wins.
              err_q <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Read mux over the pre-edge register contents.
  always_comb begin
    rdata_d = '0;
    if (addr == A_CTRL) begin
      rdata_d[1:0]   = sh_mode_q;
      rdata_d[3:2]   = sh_std_q;
      rdata_d[5:4]   = sh_word_q;
      rdata_d[7:6]   = sh_slot_q;
      rdata_d[9:8]   = sh_rate_q;
      rdata_d[EN_BIT] = sh_en_q;
    end else if (addr == A_CHEN) begin
      rdata_d[NUM_CH-1:0] = sh_chen_q;
    end else if (addr == A_STAT) begin
      rdata_d[2:0] = {act_en_q, err_q, pending};
    end
  end

  // Shadow registers and registered read port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_en_q    <= 1'b0;
      sh_mode_q  <= 2'b00;
      sh_std_q   <= 2'b00;
      sh_word_q  <= 2'b00;
      sh_slot_q  <= 2'b00;
      sh_rate_q  <= 2'b00;
      sh_chen_q  <= '1;
      rdata_q    <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        sh_mode_q <= wdata[1:0];
        sh_std_q  <= wdata[3:2];
        sh_word_q <= wdata[5:4];
        sh_slot_q <= wdata[7:6];
        sh_rate_q <= wdata[9:8];
        sh_en_q   <= wdata[EN_BIT];
      end
      if (wr_chen) begin
        sh_chen_q <= wdata[NUM_CH-1:0];
      end
      rd_valid_q <= rd_en;
      if (rd_en) begin
        rdata_q <= rdata_d;
      end
    end
  end

  assign rdata           = rdata_q;
  assign rd_valid        = rd_valid_q;
  assign cfg_enable      = act_en_q;
  assign cfg_mode        = act_mode_q;
  assign cfg_standard    = act_std_q;
  assign cfg_word_size   = act_word_q;
  assign cfg_slot_size   = act_slot_q;
  assign cfg_sample_rate = act_rate_q;
  assign cfg_ch_en       = act_chen_q;
  assign cfg_update      = cfg_update_q;

endmodule

// File: tb/tb_i2s_cfg_ctrl.sv
// Bench for i2s_cfg_ctrl: a two-slot build (checked every cycle against a
// register-image reference model) and an eight-slot build for TDM cases.

module tb_i2s_cfg_ctrl;

  localparam logic [31:0] CTRL_MASK = 32'h8000_03FF;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Two-slot instance
  logic        wr_a, rd_a, fs_a;
  logic [1:0]  addr_a;
  logic [31:0] wdata_a, rdata_a;
  logic        rd_valid_a, en_a, slot_a, upd_a;
  logic [1:0]  mode_a, std_a, word_a, rate_a, chen_a;

  // Eight-slot instance
  logic        wr_b, rd_b, fs_b;
  logic [1:0]  addr_b;
  logic [31:0] wdata_b, rdata_b;
  logic        rd_valid_b, en_b, slot_b, upd_b;
  logic [1:0]  mode_b, std_b, word_b, rate_b;
  logic [7:0]  chen_b;

  i2s_cfg_ctrl #(.NUM_CH(2), .DATA_W(32), .ADDR_W(2)) u_dut_a (
    .clk(clk), .rst(rst), .wr_en(wr_a), .rd_en(rd_a), .addr(addr_a),
    .wdata(wdata_a), .rdata(rdata_a), .rd_valid(rd_valid_a),
    .frame_start(fs_a), .cfg_enable(en_a), .cfg_mode(mode_a),
    .cfg_standard(std_a), .cfg_word_size(word_a), .cfg_slot_size(slot_a),
    .cfg_sample_rate(rate_a), .cfg_ch_en(chen_a), .cfg_update(upd_a)
  );

  i2s_cfg_ctrl #(.NUM_CH(8), .DATA_W(32), .ADDR_W(2)) u_dut_b (
    .clk(clk), .rst(rst), .wr_en(wr_b), .rd_en(rd_b), .addr(addr_b),
    .wdata(wdata_b), .rdata(rdata_b), .rd_valid(rd_valid_b),
    .frame_start(fs_b), .cfg_enable(en_b), .cfg_mode(mode_b),
    .cfg_standard(std_b), .cfg_word_size(word_b), .cfg_slot_size(slot_b),
    .cfg_sample_rate(rate_b), .cfg_ch_en(chen_b), .cfg_update(upd_b)
  );

  int checks = 0;
  int errors = 0;

  // Reference model of the two-slot instance as register images.
  logic [31:0] m_ctrl, m_chen, m_act_ctrl, m_act_chen;
  bit          m_pend, m_err, m_upd;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Legality straight from the rule list, on register images.
  function automatic bit rule_legal(input logic [31:0] c, input logic [31:0] ch, input int nch);
    int word, slot, std;
    word = int'(c[5:4]);
    slot = int'(c[7:6]);
    std  = int'(c[3:2]);
    if (word == 3) return 1'b0;
    if (slot > 1) return 1'b0;
    if (word > 0 && slot == 0) return 1'b0;
    if (std == 3 && nch <= 2) return 1'b0;
    if (std != 3 && ch > 3) return 1'b0;
    if (c[31] && ch == 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [31:0] exp_cfg_a();
    return {20'd0, m_act_ctrl[31], m_act_ctrl[1:0], m_act_ctrl[3:2], m_act_ctrl[5:4],
            m_act_ctrl[6], m_act_ctrl[9:8], m_act_chen[1:0]};
  endfunction

  function automatic logic [31:0] obs_cfg_a();
    return {20'd0, en_a, mode_a, std_a, word_a, slot_a, rate_a, chen_a};
  endfunction

  task automatic model_reset();
    m_ctrl = 32'd0;  m_chen = 32'd3;
    m_act_ctrl = 32'd0;  m_act_chen = 32'd3;
    m_pend = 1'b0;  m_err = 1'b0;  m_upd = 1'b0;
    exp_q.delete();
  endtask

  // One clock edge: advance the model with the current inputs of the
  // two-slot instance, then check all of its outputs.
  task automatic tick();
    bit rd_issued, commit, clr, apply, lg;
    logic [31:0] e;
    rd_issued = rd_a;
    if (rd_a) begin
      case (addr_a)
        2'd0:    e = m_ctrl;
        2'd1:    e = m_chen;
        2'd2:    e = {29'd0, m_act_ctrl[31], m_err, m_pend};
        default: e = 32'd0;
      endcase
      exp_q.push_back(e);
    end
    commit = wr_a && addr_a == 2'd3 && wdata_a[0];
    clr    = wr_a && addr_a == 2'd3 && wdata_a[1];
    apply  = m_pend && (!m_act_ctrl[31] || fs_a);
    lg     = rule_legal(m_ctrl, m_chen, 2);
    m_upd  = apply && lg;
    if (apply && lg) begin
      m_act_ctrl = m_ctrl;
      m_act_chen = m_chen;
    end
    if (apply && !lg) m_err = 1'b1;
    else if (clr) m_err = 1'b0;
    if (apply) m_pend = 1'b0;
    else if (commit) m_pend = 1'b1;
    if (wr_a && addr_a == 2'd0) m_ctrl = wdata_a & CTRL_MASK;
    if (wr_a && addr_a == 2'd1) m_chen = wdata_a & 32'h3;
    @(posedge clk);
    #1;
    check("cfg_a", obs_cfg_a(), exp_cfg_a());
    check("upd_a", {31'd0, upd_a}, {31'd0, m_upd});
    check("rd_valid_a", {31'd0, rd_valid_a}, {31'd0, rd_issued});
    if (rd_issued) begin
      e = exp_q.pop_front();
      check("rdata_a", rdata_a, e);
    end
  endtask

  task automatic a_op(input bit wr, input bit rd, input logic [1:0] a,
                      input logic [31:0] d, input bit fs);
    wr_a = wr; rd_a = rd; addr_a = a; wdata_a = d; fs_a = fs;
    tick();
    wr_a = 1'b0; rd_a = 1'b0; addr_a = 2'd0; wdata_a = 32'd0; fs_a = 1'b0;
  endtask

  task automatic b_op(input bit wr, input bit rd, input logic [1:0] a,
                      input logic [31:0] d, input bit fs);
    wr_b = wr; rd_b = rd; addr_b = a; wdata_b = d; fs_b = fs;
    tick();
    wr_b = 1'b0; rd_b = 1'b0; addr_b = 2'd0; wdata_b = 32'd0; fs_b = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    model_reset();
    check("rst_cfg_a", obs_cfg_a(), 32'h003);
    check("rst_upd_a", {31'd0, upd_a}, 32'd0);
    check("rst_rd_valid_a", {31'd0, rd_valid_a}, 32'd0);
    check("rst_rdata_a", rdata_a, 32'd0);
    check("rst_cfg_b", {14'd0, en_b, mode_b, std_b, word_b, slot_b, rate_b, chen_b}, 32'h0FF);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  function automatic logic [31:0] gen_ctrl();
    logic [1:0] mode, std, word, slot, rate;
    logic       en;
    mode = 2'($urandom_range(0, 3));
    std  = ($urandom_range(0, 5) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
    word = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
    if ($urandom_range(0, 9) == 0) slot = 2'($urandom_range(2, 3));
    else if (word == 2'd0) slot = 2'($urandom_range(0, 1));
    else slot = ($urandom_range(0, 4) == 0) ? 2'd0 : 2'd1;
    rate = 2'($urandom_range(0, 3));
    en   = 1'($urandom_range(0, 1));
    return ($urandom & 32'h7FFF_FC00) | {en, 21'd0, rate, slot, word, std, mode};
  endfunction

  initial begin
    logic [31:0] d;
    bit wr, rd, fs;
    logic [1:0] a;
    wr_a = 0; rd_a = 0; fs_a = 0; addr_a = 0; wdata_a = 0;
    wr_b = 0; rd_b = 0; fs_b = 0; addr_b = 0; wdata_b = 0;
    model_reset();
    @(posedge clk);
    #1;
    do_reset();

    // Illegal: 24-bit word in a 16-bit slot, link disabled.
    a_op(1, 0, 2'd0, 32'h8000_0015, 0);
    a_op(1, 0, 2'd1, 32'h0000_0003, 0);
    a_op(1, 0, 2'd3, 32'h0000_0001, 0);
    a_op(0, 1, 2'd2, 32'd0, 0);
    check("status_pending", rdata_a, 32'h1);
    a_op(0, 1, 2'd2, 32'd0, 0);
    check("status_err", rdata_a, 32'h2);
    check("illegal_keeps_enable", {31'd0, en_a}, 32'd0);

    // Legal apply with link disabled: one edge after the commit.
    a_op(1, 0, 2'd3, 32'h0000_0002, 0);
    a_op(1, 0, 2'd0, 32'h8000_0055, 0);
    a_op(1, 0, 2'd3, 32'h0000_0001, 0);
    a_op(0, 0, 2'd0, 32'd0, 0);
    check("legal_upd", {31'd0, upd_a}, 32'd1);
    check("legal_en", {31'd0, en_a}, 32'd1);
    check("legal_word", {30'd0, word_a}, 32'd1);
    check("legal_slot", {31'd0, slot_a}, 32'd1);
    a_op(0, 1, 2'd2, 32'd0, 0);
    check("legal_upd_one_cycle", {31'd0, upd_a}, 32'd0);
    check("legal_status", rdata_a, 32'h4);

    // Running link: waits for a frame boundary.
    a_op(1, 0, 2'd0, 32'h8000_0355, 0);
    a_op(1, 0, 2'd3, 32'h0000_0001, 0);
    for (int i = 0; i < 20; i++) a_op(0, 0, 2'd0, 32'd0, 0);
    a_op(0, 1, 2'd2, 32'd0, 0);
    check("wait_status", rdata_a, 32'h5);
    check("wait_rate_old", {30'd0, rate_a}, 32'd0);
    a_op(0, 0, 2'd0, 32'd0, 1);
    check("frame_rate_new", {30'd0, rate_a}, 32'd3);
    check("frame_upd", {31'd0, upd_a}, 32'd1);

    // CTRL write on the applying edge lands in the shadow only.
    a_op(1, 0, 2'd0, 32'h8000_0255, 0);
    a_op(1, 0, 2'd3, 32'h0000_0001, 0);
    a_op(1, 0, 2'd0, 32'h8000_0155, 1);
    check("same_edge_rate", {30'd0, rate_a}, 32'd2);
    a_op(0, 1, 2'd0, 32'd0, 0);
    check("same_edge_shadow", rdata_a, 32'h8000_0155);
    a_op(0, 1, 2'd2, 32'd0, 0);
    check("same_edge_pending", rdata_a, 32'h4);

    // Clear-err on the edge of an illegal apply: err stays set.
    a_op(1, 0, 2'd0, 32'h8000_0015, 0);
    a_op(1, 0, 2'd3, 32'h0000_0001, 0);
    a_op(1, 0, 2'd3, 32'h0000_0002, 1);
    a_op(0, 1, 2'd2, 32'd0, 0);
    check("err_set_wins", rdata_a, 32'h6);
    check("illegal_rate_kept", {30'd0, rate_a}, 32'd2);

    // Simultaneous write and read returns the old value.
    a_op(1, 1, 2'd0, 32'h0000_0000, 0);
    check("rw_same_cycle", rdata_a, 32'h8000_0015);

    // Reset while waiting discards the commit.
    a_op(1, 0, 2'd0, 32'h8000_0055, 0);
    a_op(1, 0, 2'd3, 32'h0000_0003, 0);
    a_op(0, 0, 2'd0, 32'd0, 0);
    do_reset();
    a_op(0, 1, 2'd2, 32'd0, 0);
    check("post_rst_status", rdata_a, 32'h0);
    check("post_rst_chen", {30'd0, chen_a}, 32'h3);

    // TDM needs more than two slots.
    a_op(1, 0, 2'd0, 32'h0000_000C, 0);
    a_op(1, 0, 2'd3, 32'h0000_0001, 0);
    a_op(0, 0, 2'd0, 32'd0, 0);
    a_op(0, 1, 2'd2, 32'd0, 0);
    check("tdm_two_slot_err", rdata_a, 32'h2);

    // Eight-slot build: TDM on slots 4..7.
    b_op(1, 0, 2'd0, 32'h8000_000C, 0);
    b_op(1, 0, 2'd1, 32'h0000_00F0, 0);
    b_op(1, 0, 2'd3, 32'h0000_0001, 0);
    b_op(0, 0, 2'd0, 32'd0, 0);
    check("b_upd", {31'd0, upd_b}, 32'd1);
    check("b_ch_en", {24'd0, chen_b}, 32'hF0);
    check("b_std", {30'd0, std_b}, 32'd3);
    b_op(0, 1, 2'd2, 32'd0, 0);
    check("b_status", rdata_b, 32'h4);
    // Non-TDM standard with high slots enabled is illegal.
    b_op(1, 0, 2'd0, 32'h8000_0000, 0);
    b_op(1, 0, 2'd3, 32'h0000_0001, 0);
    b_op(0, 0, 2'd0, 32'd0, 1);
    check("b_illegal_upd", {31'd0, upd_b}, 32'd0);
    b_op(0, 1, 2'd2, 32'd0, 0);
    check("b_err_status", rdata_b, 32'h6);
    check("b_ch_en_kept", {24'd0, chen_b}, 32'hF0);

    // Randomised traffic on the two-slot build against the model.
    for (int n = 0; n < 800; n++) begin
      wr = ($urandom_range(0, 99) < 40);
      rd = ($urandom_range(0, 2) == 0);
      a  = 2'($urandom_range(0, 3));
      fs = ($urandom_range(0, 7) == 0);
      case (a)
        2'd0:    d = gen_ctrl();
        2'd1:    d = ($urandom & 32'hFFFF_FFFC) | 32'($urandom_range(0, 3));
        2'd3:    d = ($urandom_range(0, 3) == 0) ? 32'd2 : 32'd1;
        default: d = $urandom;
      endcase
      a_op(wr, rd, a, d, fs);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2s_cfg_ctrl.md
Name: i2s_cfg_ctrl

Overview:
- Parametrised configuration/control unit for the I2S transceiver; successor to the fixed single-struct operating-mode definition.
- Host writes go into shadow registers; a commit command transfers them to the active configuration only at a frame boundary, or immediately when the link is disabled, after a legality check.
- Adds TDM standard, multi-slot channel enables, an extended sample-rate set, sticky error status and an update pulse.
- Sits between the host register bus and the clock generator / serializer / deserializer.

Parameters:
NUM_CH, 2, slots per frame (2..16); width of channel-enable mask
DATA_W, 32, host bus data width (>= max(16, NUM_CH))
ADDR_W, 2, host bus address width

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
wr_en  in  1  host write strobe
rd_en  in  1  host read strobe
addr  in  ADDR_W  register address
wdata  in  DATA_W  write data
rdata  out  DATA_W  read data, registered
rd_valid  out  1  rdata valid, one cycle after rd_en
frame_start  in  1  one-cycle pulse from WS generator at frame boundary
cfg_enable  out  1  active link enable
cfg_mode  out  2  00 SR, 10 MR, 01 ST, 11 MT
cfg_standard  out  2  00 I2S, 01 MSB, 10 LSB, 11 TDM
cfg_word_size  out  2  00 16b, 01 24b, 10 32b
cfg_slot_size  out  1  0 16b, 1 32b
cfg_sample_rate  out  2  00 44.1k, 01 48k, 10 88.2k, 11 96k
cfg_ch_en  out  NUM_CH  active slot enables
cfg_update  out  1  one-cycle pulse: active config just changed

Behaviour:
- Register map: 0 CTRL (RW shadow): [1:0] mode, [3:2] standard, [5:4] word_size, [7:6] slot_size (2-bit field; only bit 6 drives cfg_slot_size), [9:8] sample_rate, [31] enable. 1 CHEN (RW shadow): [NUM_CH-1:0]. 2 STATUS (RO): [0] pending, [1] err, [2] active enable. 3 CMD (WO, reads 0): [0] commit, [1] clear err.
- Reset: all outputs as follows. cfg_enable=0, mode=00, standard=00, word=00, slot=0, rate=00, cfg_ch_en=all ones, cfg_update=0, rdata=0, rd_valid=0. Shadows hold the same values; pending=0, err=0, FSM=IDLE. Reset mid-wait discards the pending commit.
- Reads: rdata/rd_valid update at the edge after rd_en. Unused bits read 0. Write to a RO/unused field is ignored. wr_en and rd_en together: both are performed, and the read returns the pre-write value.
- FSM states:
  - IDLE: pending=0. A CMD.commit write moves to WAIT; pending=1 after that edge.
  - WAIT: pending=1. Apply occurs at the first edge where (cfg_enable==0) or (frame_start==1). A frame_start in the same cycle as the commit write is ignored. A repeated commit in WAIT has no effect.
  - APPLY: combinational decision on that edge, not a separate state.
    - Legal: active <= shadow, cfg_update=1 for exactly one cycle, state returns to IDLE.
    - Illegal: active unchanged, err=1 (sticky), cfg_update=0, pending cleared, state returns to IDLE.
- Latency: with the link disabled, a commit written at edge E0 produces new cfg_* and cfg_update visible after E0+1.
- Illegal combinations:
  - word_size==11.
  - slot_size field != 00/01.
  - word_size>00 with slot=16b.
  - standard==11 with NUM_CH<=2.
  - standard!=11 with any CHEN bit above [1] set.
  - enable==1 with CHEN==0.
- Apply uses the shadow value held before that edge. A CTRL/CHEN write on the same edge lands in the shadow only and is not committed.
- err clear and a new error on the same edge: set wins. Clearing err does not affect pending.

Test Plan:
- Reset mid-operation: assert rst while in WAIT -> all cfg_* at defaults, cfg_ch_en=2'b11, STATUS reads 0, no cfg_update.
- Disabled link: write CTRL=0x8000_0015 (mode 01, std 01, word 01, slot 16b), CHEN=3, commit -> illegal (24b in 16b slot), err=1, cfg_* unchanged.
- Legal apply: write CTRL=0x8000_0055 (slot 32b), commit with link disabled -> after one edge cfg_enable=1, cfg_word_size=01, cfg_slot_size=1, cfg_update high one cycle, STATUS=0x4.
- Running link: write CTRL rate=11, commit, hold frame_start low 20 cycles -> STATUS.pending=1, cfg_sample_rate unchanged; pulse frame_start -> rate=11 with cfg_update on that edge.
- Same-edge boundaries:
  - CTRL write coincident with the applying frame_start -> active takes the old shadow, shadow reads the new value, pending=0.
  - Clear-err coincident with an illegal apply -> err stays 1.
- NUM_CH=8 build: standard=11, CHEN=0xF0, enable -> legal, cfg_ch_en=0xF0. With NUM_CH=2, standard=11 -> err=1.
